// File: rtl/lsq_partitioned_ram_reconfig_if.sv
// Port bundle for the LSQ partitioned RAM: read/write lanes, partition power
// requests and readiness/conflict status.
interface lsq_partitioned_ram_reconfig_if #(
  parameter int unsigned RPORT     = 2,
  parameter int unsigned WPORT     = 4,
  parameter int unsigned INDEX     = 5,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned NUM_PARTS = 4
);
  logic [RPORT*INDEX-1:0] addr_i;
  logic [RPORT*WIDTH-1:0] data_o;
  logic [WPORT*INDEX-1:0] addrWr_i;
  logic [WPORT*WIDTH-1:0] dataWr_i;
  logic [WPORT-1:0]       we_i;
  logic [WPORT-1:0]       writeLaneActive_i;
  logic [NUM_PARTS-1:0]   partitionActive_i;
  logic [NUM_PARTS-1:0]   partReady_o;
  logic                   ramReady_o;
  logic                   wrConflict_o;

  modport master (
    output addr_i, addrWr_i, dataWr_i, we_i, writeLaneActive_i, partitionActive_i,
    input  data_o, partReady_o, ramReady_o, wrConflict_o
  );

  modport slave (
    input  addr_i, addrWr_i, dataWr_i, we_i, writeLaneActive_i, partitionActive_i,
    output data_o, partReady_o, ramReady_o, wrConflict_o
  );
endinterface

// File: rtl/lsq_partitioned_ram_reconfig.sv
// Multi-port partitioned RAM for LSQ side tables. Each partition is scrubbed to
// CLR_VALUE on activation and only accepts dispatch writes / serves reads once
// its scrub has completed.
module lsq_partitioned_ram_reconfig #(
  parameter int unsigned     RPORT         = 2,
  parameter int unsigned     WPORT         = 4,
  parameter int unsigned     DEPTH         = 32,
  parameter int unsigned     INDEX         = 5,
  parameter int unsigned     WIDTH         = 8,
  parameter int unsigned     NUM_PARTS     = 4,
  parameter int unsigned     NUM_PARTS_LOG = 2,
  parameter int unsigned     RD_LATENCY    = 0,
  parameter logic [WIDTH-1:0] CLR_VALUE    = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  lsq_partitioned_ram_reconfig_if.slave  bus
);

  localparam int unsigned ROWS   = DEPTH / NUM_PARTS;
  localparam int unsigned ROW_W  = INDEX - NUM_PARTS_LOG;
  localparam int unsigned CNT_W  = (ROW_W == 0) ? 1 : ROW_W;
  localparam int unsigned PSEL_W = (NUM_PARTS_LOG == 0) ? 1 : NUM_PARTS_LOG;

  typedef enum logic [1:0] {P_OFF, P_CLEAR, P_READY} pstate_e;

  // Partition number of an entry address (always 0 with a single partition).
  function automatic logic [PSEL_W-1:0] part_of(input logic [INDEX-1:0] a);
    return PSEL_W'(a >> ROW_W);
  endfunction

  pstate_e              state_q [NUM_PARTS];
  pstate_e              state_d [NUM_PARTS];
  logic [CNT_W-1:0]     cnt_q   [NUM_PARTS];
  logic [CNT_W-1:0]     cnt_d   [NUM_PARTS];
  logic [INDEX-1:0]     clr_addr [NUM_PARTS];
  logic [NUM_PARTS-1:0] clr_en;
  logic [NUM_PARTS-1:0] ready_q;

  logic [WIDTH-1:0]     mem [DEPTH];

  logic [INDEX-1:0]     wr_addr [WPORT];
  logic [WIDTH-1:0]     wr_data [WPORT];
  logic [WPORT-1:0]     wr_eff;
  logic                 conflict_c;
  logic                 conflict_q;
  logic [RPORT*WIDTH-1:0] rd_c;

  // Per-partition reconfiguration FSM: next state, scrub counter and scrub strobe.
  always_comb begin
    for (int p = 0; p < int'(NUM_PARTS); p++) begin
      state_d[p]  = state_q[p];
      cnt_d[p]    = cnt_q[p];
      clr_en[p]   = 1'b0;
      clr_addr[p] = INDEX'(p * int'(ROWS)) | INDEX'(cnt_q[p]);
      if (!bus.partitionActive_i[p]) begin
        state_d[p] = P_OFF;
        cnt_d[p]   = '0;
      end else begin
        case (state_q[p])
          P_OFF: begin
            state_d[p] = P_CLEAR;
            cnt_d[p]   = '0;
          end
          P_CLEAR: begin
            clr_en[p] = 1'b1;
            cnt_d[p]  = cnt_q[p] + CNT_W'(1);
            if (cnt_q[p] == CNT_W'(ROWS - 1)) begin
              state_d[p] = P_READY;
              cnt_d[p]   = '0;
            end
          end
          P_READY: state_d[p] = P_READY;
          default: begin
            state_d[p] = P_OFF;
            cnt_d[p]   = '0;
          end
        endcase
      end
    end
  end

  // FSM state, counters and registered READY decode.
  always_ff @(posedge clk) begin
    for (int p = 0; p < int'(NUM_PARTS); p++) begin
      if (reset) begin
        state_q[p] <= P_OFF;
        cnt_q[p]   <= '0;
        ready_q[p] <= 1'b0;
      end else begin
        state_q[p] <= state_d[p];
        cnt_q[p]   <= cnt_d[p];
        ready_q[p] <= (state_d[p] == P_READY);
      end
    end
  end

  // Effective dispatch writes and same-address collision detect.
  always_comb begin
    conflict_c = 1'b0;
    for (int w = 0; w < int'(WPORT); w++) begin
      wr_addr[w] = bus.addrWr_i[w*INDEX +: INDEX];
      wr_data[w] = bus.dataWr_i[w*WIDTH +: WIDTH];
      wr_eff[w]  = bus.we_i[w] & bus.writeLaneActive_i[w] & ready_q[part_of(wr_addr[w])];
    end
    for (int i = 0; i < int'(WPORT); i++) begin
      for (int j = i + 1; j < int'(WPORT); j++) begin
        if (wr_eff[i] && wr_eff[j] && (wr_addr[i] == wr_addr[j])) conflict_c = 1'b1;
      end
    end
  end

  // Array update: scrub rows first, then dispatch lanes in ascending order so the
  // highest-indexed lane wins a same-address collision.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int p = 0; p < int'(NUM_PARTS); p++) begin
        if (clr_en[p]) mem[clr_addr[p]] <= CLR_VALUE;
      end
      for (int w = 0; w < int'(WPORT); w++) begin
        if (wr_eff[w]) mem[wr_addr[w]] <= wr_data[w];
      end
    end
  end

  // One-cycle collision pulse.
  always_ff @(posedge clk) begin
    if (reset) conflict_q <= 1'b0;
    else       conflict_q <= conflict_c;
  end

  // Array read; partitions that are not READY read as CLR_VALUE.
  always_comb begin
    rd_c = '0;
    for (int r = 0; r < int'(RPORT); r++) begin
      rd_c[r*WIDTH +: WIDTH] = ready_q[part_of(bus.addr_i[r*INDEX +: INDEX])]
                             ? mem[bus.addr_i[r*INDEX +: INDEX]] : CLR_VALUE;
    end
  end

  if (RD_LATENCY == 0) begin : g_rd_comb
    assign bus.data_o = rd_c;
  end else begin : g_rd_reg
    logic [RPORT*WIDTH-1:0] data_q;
    // Registered read stage capturing pre-write data.
    always_ff @(posedge clk) begin
      if (reset) data_q <= '0;
      else       data_q <= rd_c;
    end
    assign bus.data_o = data_q;
  end

  assign bus.partReady_o  = ready_q;
  assign bus.ramReady_o   = (|bus.partitionActive_i) & (&(ready_q | ~bus.partitionActive_i));
  assign bus.wrConflict_o = conflict_q;

endmodule
